r_round_robin_burst_arbiter: RTL and testbench



---
 rtl/r_round_robin_burst_arbiter.sv | 140 ++++++++++++++
 tb/tb_r_round_robin_burst_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_round_robin_burst_arbiter.sv
// r_round_robin_burst_arbiter
//   Shares one upstream AXI R return path between 5 slave R channels.
//   Round-robin grant, held for a whole burst and released on the RLAST
//   handshake. Counts beats of the current burst and raises a sticky
//   error when a burst runs past MAX_BEATS beats without RLAST.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   RVALID_S/RLAST_S        per-slave valid/last, bit i = slave i
//   RID_S/RDATA_S/RRESP_S   packed per-slave payload, slave i at [i*W +: W]
//   RREADY_S                per-slave ready, only the granted slave sees RREADY_M
//   RVALID_M/RLAST_M/RID_M/RDATA_M/RRESP_M   muxed master-side channel
//   RREADY_M                master-side ready
//   R_SLV_sel               granted slave 0..4, 5 = none
//   beat_cnt                beats accepted in the current burst (saturates at 511)
//   overrun_err             sticky burst-overrun flag
module r_round_robin_burst_arbiter #(
   parameter int sID_width = 6,
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 256
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4:0]             RVALID_S,
   input  logic [4:0]             RLAST_S,
   input  logic [5*sID_width-1:0] RID_S,
   input  logic [5*DATA_W-1:0]    RDATA_S,
   input  logic [9:0]             RRESP_S,
   output logic [4:0]             RREADY_S,
   output logic                   RVALID_M,
   output logic                   RLAST_M,
   output logic [sID_width-1:0]   RID_M,
   output logic [DATA_W-1:0]      RDATA_M,
   output logic [1:0]             RRESP_M,
   input  logic                   RREADY_M,
   output logic [2:0]             R_SLV_sel,
   output logic [8:0]             beat_cnt,
   output logic                   overrun_err
);

   localparam logic [2:0] SEL_NONE = 3'd5;
   localparam logic [8:0] MAX_CNT  = 9'(MAX_BEATS);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t      state, state_n;
   logic [2:0]  sel_n;
   logic [2:0]  last_grant, last_grant_n;
   logic [8:0]  beat_cnt_n;
   logic        overrun_n;
   logic        found;
   logic [2:0]  pick;
   logic        beat;
   int unsigned idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         R_SLV_sel   <= SEL_NONE;
         last_grant  <= 3'd4;
         beat_cnt    <= '0;
         overrun_err <= 1'b0;
      end else begin
         state       <= state_n;
         R_SLV_sel   <= sel_n;
         last_grant  <= last_grant_n;
         beat_cnt    <= beat_cnt_n;
         overrun_err <= overrun_n;
      end
   end

   // Round-robin pick: first requester after last_grant, wrapping mod 5.
   always_comb begin
      found = 1'b0;
      pick  = SEL_NONE;
      idx   = 0;
      for (int unsigned k = 1; k <= 5; k++) begin
         idx = (32'(last_grant) + k) % 5;
         if (!found && RVALID_S[3'(idx)]) begin
            found = 1'b1;
            pick  = 3'(idx);
         end
      end
   end

   always_comb begin
      state_n      = state;
      sel_n        = R_SLV_sel;
      last_grant_n = last_grant;
      beat_cnt_n   = beat_cnt;
      overrun_n    = overrun_err;
      RREADY_S     = '0;
      RVALID_M     = 1'b0;
      RLAST_M      = 1'b0;
      RID_M        = '0;
      RDATA_M      = '0;
      RRESP_M      = '0;
      beat         = 1'b0;

      case (state)
         IDLE: begin
            if (found) begin
               state_n      = GRANT;
               sel_n        = pick;
               last_grant_n = pick;
            end
         end
         GRANT: begin
            if (R_SLV_sel < SEL_NONE) begin
               RVALID_M = RVALID_S[R_SLV_sel];
               RLAST_M  = RLAST_S[R_SLV_sel];
               RID_M    = RID_S[R_SLV_sel*sID_width +: sID_width];
               RDATA_M  = RDATA_S[R_SLV_sel*DATA_W +: DATA_W];
               RRESP_M  = RRESP_S[R_SLV_sel*2 +: 2];
               // Ready is withheld while reset is high so no beat completes
               // in the cycle that aborts the grant.
               RREADY_S[R_SLV_sel] = RREADY_M && !reset;
               beat = RVALID_S[R_SLV_sel] && RREADY_M && !reset;
               if (beat) begin
                  if (RLAST_S[R_SLV_sel]) begin
                     state_n    = IDLE;
                     sel_n      = SEL_NONE;
                     beat_cnt_n = '0;
                  end else begin
                     if (beat_cnt == MAX_CNT)
                        overrun_n = 1'b1;
                     if (beat_cnt != '1)
                        beat_cnt_n = beat_cnt + 9'd1;
                  end
               end
            end
         end
         default: begin
            state_n = IDLE;
            sel_n   = SEL_NONE;
         end
      endcase
   end

endmodule

// File: tb/tb_r_round_robin_burst_arbiter.sv
// Directed bench for r_round_robin_burst_arbiter. Behavioural slaves feed
// bursts; every master-side beat is popped from a queue of expected beats
// filled in the grant order the bench predicts.
module tb_r_round_robin_burst_arbiter;
   localparam int SW = 6;
   localparam int DW = 32;
   localparam int N  = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic [4:0]      RVALID_S, RLAST_S, RREADY_S;
   logic [5*SW-1:0] RID_S;
   logic [5*DW-1:0] RDATA_S;
   logic [9:0]      RRESP_S;
   logic            RVALID_M, RLAST_M, RREADY_M;
   logic [SW-1:0]   RID_M;
   logic [DW-1:0]   RDATA_M;
   logic [1:0]      RRESP_M;
   logic [2:0]      R_SLV_sel;
   logic [8:0]      beat_cnt;
   logic            overrun_err;

   always #5 clk = ~clk;

   r_round_robin_burst_arbiter #(.sID_width(SW), .DATA_W(DW), .MAX_BEATS(4)) dut (
      .clk(clk), .reset(reset),
      .RVALID_S(RVALID_S), .RLAST_S(RLAST_S), .RID_S(RID_S), .RDATA_S(RDATA_S),
      .RRESP_S(RRESP_S), .RREADY_S(RREADY_S),
      .RVALID_M(RVALID_M), .RLAST_M(RLAST_M), .RID_M(RID_M), .RDATA_M(RDATA_M),
      .RRESP_M(RRESP_M), .RREADY_M(RREADY_M),
      .R_SLV_sel(R_SLV_sel), .beat_cnt(beat_cnt), .overrun_err(overrun_err)
   );

   typedef struct {
      int            sel;
      logic [SW-1:0] id;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } beat_t;

   beat_t exp_q[$];
   int errors = 0;
   int checks = 0;

   int len[N], bt[N], tag[N], nb[N];
   bit act[N], hold[N], hs[N];

   function automatic logic [SW-1:0] mkid(int i, int t);
      return SW'(i * 8 + t % 8);
   endfunction
   function automatic logic [DW-1:0] mkdata(int i, int t, int b);
      return {8'(i), 8'(t), 16'(b)};
   endfunction
   function automatic logic [1:0] mkresp(int i, int b);
      return 2'(i + b);
   endfunction

   task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tg, obs, expv);
      end
   endtask

   task automatic drive();
      RVALID_S = '0; RLAST_S = '0; RID_S = '0; RDATA_S = '0; RRESP_S = '0;
      for (int i = 0; i < N; i++) begin
         if (act[i]) begin
            RVALID_S[i]           = !hold[i];
            RLAST_S[i]            = (bt[i] == len[i] - 1);
            RID_S[i*SW +: SW]     = mkid(i, tag[i]);
            RDATA_S[i*DW +: DW]   = mkdata(i, tag[i], bt[i]);
            RRESP_S[i*2 +: 2]     = mkresp(i, bt[i]);
         end
      end
   endtask

   task automatic start_burst(input int i, input int n, input int t, input int bursts);
      act[i] = 1'b1; len[i] = n; bt[i] = 0; tag[i] = t; nb[i] = bursts; hold[i] = 1'b0;
   endtask

   task automatic expect_beat(input int i, input int t, input int b, input bit last);
      beat_t e;
      e.sel = i; e.id = mkid(i, t); e.data = mkdata(i, t, b);
      e.resp = mkresp(i, b); e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic expect_burst(input int i, input int n, input int t);
      for (int b = 0; b < n; b++) expect_beat(i, t, b, b == n - 1);
   endtask

   task automatic monitor();
      beat_t e;
      for (int i = 0; i < N; i++) hs[i] = RVALID_S[i] && RREADY_S[i];
      chk("rready_onehot", 32'($countones(RREADY_S) <= 1), 1);
      if (RVALID_M && RREADY_M && !reset) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            chk("beat_sel", R_SLV_sel, e.sel);
            chk("beat_rid", RID_M, e.id);
            chk("beat_rdata", RDATA_M, e.data);
            chk("beat_rresp", RRESP_M, e.resp);
            chk("beat_rlast", RLAST_M, e.last);
            chk("beat_rready_s", RREADY_S, 32'(1) << e.sel);
         end
      end
   endtask

   // Samples just after the negedge, advances the slave models after the
   // posedge, and returns at the next negedge.
   task automatic tick();
      #1;
      monitor();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            if (bt[i] == len[i] - 1) begin
               if (nb[i] > 1) begin
                  nb[i]--; tag[i] += 5; bt[i] = 0;
               end else begin
                  act[i] = 1'b0;
               end
            end else begin
               bt[i]++;
            end
         end
      end
      drive();
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   int ord[6] = '{0, 1, 2, 3, 4, 0};

   initial begin
      reset = 1'b1;
      RREADY_M = 1'b0;
      for (int i = 0; i < N; i++) begin
         act[i] = 0; hold[i] = 0; hs[i] = 0; len[i] = 1; bt[i] = 0; tag[i] = 0; nb[i] = 0;
      end
      drive();
      @(negedge clk);
      tick();
      tick();
      reset = 1'b0;
      chk("rst_sel", R_SLV_sel, 5);
      chk("rst_beat_cnt", beat_cnt, 0);
      chk("rst_overrun", overrun_err, 0);
      chk("rst_rvalid_m", RVALID_M, 0);
      chk("rst_rready_s", RREADY_S, 0);

      // single slave, 4-beat burst
      RREADY_M = 1'b1;
      start_burst(0, 4, 1, 1);
      expect_burst(0, 4, 1);
      drive();
      #1;
      chk("t1_pre_sel", R_SLV_sel, 5);
      chk("t1_idle_rvalid_m", RVALID_M, 0);
      tick();
      chk("t1_grant", R_SLV_sel, 0);
      chk("t1_rready_s", RREADY_S, 5'b00001);
      for (int j = 1; j <= 3; j++) begin
         tick();
         chk("t1_sel_hold", R_SLV_sel, 0);
         chk("t1_beat_cnt", beat_cnt, j);
      end
      tick();
      chk("t1_release", R_SLV_sel, 5);
      chk("t1_cnt_clear", beat_cnt, 0);

      // all slaves requesting, 2-beat bursts
      pulse_reset();
      for (int i = 0; i < N; i++) start_burst(i, 2, 10 + i, (i == 0) ? 2 : 1);
      for (int k = 0; k < 6; k++) expect_burst(ord[k], 2, 10 + k);
      drive();
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("t2_grant_order", R_SLV_sel, ord[k]);
         tick();
         chk("t2_mid_cnt", beat_cnt, 1);
         tick();
         chk("t2_bubble", R_SLV_sel, 5);
      end

      // grant held while the granted slave stalls mid-burst
      start_burst(2, 3, 20, 1);
      expect_burst(2, 3, 20);
      expect_burst(1, 2, 21);
      drive();
      tick();
      chk("t3_grant2", R_SLV_sel, 2);
      tick();
      chk("t3_cnt1", beat_cnt, 1);
      start_burst(1, 2, 21, 1);
      hold[2] = 1'b1;
      drive();
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("t3_hold_sel", R_SLV_sel, 2);
         chk("t3_hold_cnt", beat_cnt, 1);
         chk("t3_no_rready1", RREADY_S[1], 0);
      end
      hold[2] = 1'b0;
      drive();
      tick();
      chk("t3_cnt2", beat_cnt, 2);
      tick();
      chk("t3_release", R_SLV_sel, 5);
      tick();
      chk("t3_grant1", R_SLV_sel, 1);
      tick();
      tick();
      chk("t3_done", R_SLV_sel, 5);

      // RREADY_M toggling on slave 4
      start_burst(4, 3, 30, 1);
      expect_burst(4, 3, 30);
      drive();
      tick();
      chk("t4_grant4", R_SLV_sel, 4);
      tick();
      chk("t4_cnt_a", beat_cnt, 1);
      RREADY_M = 1'b0;
      #1;
      chk("t4_data_pre", RDATA_M, mkdata(4, 30, 1));
      tick();
      chk("t4_cnt_b", beat_cnt, 1);
      chk("t4_data_stable", RDATA_M, mkdata(4, 30, 1));
      chk("t4_sel_stable", R_SLV_sel, 4);
      RREADY_M = 1'b1;
      tick();
      chk("t4_cnt_c", beat_cnt, 2);
      RREADY_M = 1'b0;
      tick();
      chk("t4_cnt_d", beat_cnt, 2);
      RREADY_M = 1'b1;
      tick();
      chk("t4_release", R_SLV_sel, 5);
      chk("t4_cnt_clear", beat_cnt, 0);

      // overrun: 6 beats against a 4-beat limit
      start_burst(3, 6, 50, 1);
      expect_burst(3, 6, 50);
      drive();
      tick();
      chk("t5_grant3", R_SLV_sel, 3);
      for (int j = 1; j <= 4; j++) tick();
      chk("t5_cnt4", beat_cnt, 4);
      chk("t5_no_overrun", overrun_err, 0);
      tick();
      chk("t5_cnt5", beat_cnt, 5);
      chk("t5_overrun", overrun_err, 1);
      chk("t5_still_locked", R_SLV_sel, 3);
      tick();
      chk("t5_release", R_SLV_sel, 5);
      chk("t5_sticky", overrun_err, 1);
      tick();
      chk("t5_sticky2", overrun_err, 1);
      pulse_reset();
      chk("t5_rst_clear", overrun_err, 0);

      // reset on beat 2 of a slave-0 burst
      start_burst(0, 4, 40, 1);
      expect_beat(0, 40, 0, 1'b0);
      drive();
      tick();
      chk("t6_grant0", R_SLV_sel, 0);
      tick();
      chk("t6_cnt1", beat_cnt, 1);
      reset = 1'b1;
      #1;
      chk("t6_rready_in_rst", RREADY_S, 0);
      tick();
      reset = 1'b0;
      chk("t6_sel", R_SLV_sel, 5);
      chk("t6_cnt", beat_cnt, 0);
      chk("t6_rready", RREADY_S, 0);
      for (int b = 1; b < 4; b++) expect_beat(0, 40, b, b == 3);
      start_burst(1, 1, 41, 1);
      expect_burst(1, 1, 41);
      drive();
      tick();
      chk("t6_regrant0", R_SLV_sel, 0);
      tick();
      tick();
      tick();
      chk("t6_release", R_SLV_sel, 5);
      tick();
      chk("t6_grant1", R_SLV_sel, 1);
      tick();
      chk("t6_single_beat", R_SLV_sel, 5);
      tick();

      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
